// File: rtl/psys_in128_frame_arbiter.sv
// psys_in128_frame_arbiter: frame-locked round-robin arbiter sharing the 128-bit packer input between NUM_SRC AXI-Stream sources.
// Ports: clk/rst_n (async active-low); s_axis_* per-source inputs (source i data at [i*DW +: DW]), s_axis_tready per-source ready;
// m_axis_* stream to the packer (tlast on the last beat of each frame); grant one-hot owner (zero when idle); busy while a frame is open.
// Optional: define PSYS_ARB_FRAME_CNT_EN to add frame_cnt (16-bit completed-frame counter per source, slice i at [i*16 +: 16]).
module psys_in128_frame_arbiter #(
  parameter int NUM_SRC         = 4,
  parameter int BEATS_PER_FRAME = 12,
  parameter int DW              = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_SRC*DW-1:0] s_axis_tdata,
  input  logic [NUM_SRC-1:0]    s_axis_tvalid,
  output logic [NUM_SRC-1:0]    s_axis_tready,
  output logic [DW-1:0]         m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [NUM_SRC-1:0]    grant,
  output logic                  busy
`ifdef PSYS_ARB_FRAME_CNT_EN
  ,
  output logic [NUM_SRC*16-1:0] frame_cnt
`endif
);
  localparam int IW = $clog2(NUM_SRC);
  localparam int CW = BEATS_PER_FRAME > 1 ? $clog2(BEATS_PER_FRAME) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS_PER_FRAME - 1);
  typedef enum logic [1:0] {IDLE, ARB, XFER} state_t;
  state_t              r_state, w_next;
  logic [NUM_SRC-1:0]  r_req, r_grant, w_pick;
  logic [IW-1:0]       r_rr_last, w_g;
  logic [CW-1:0]       r_cnt;
  logic                r_busy, w_hs, w_end;
  logic [DW-1:0]       w_data;
  // Scan from the highest offset down so the nearest requester after rr_last wins.
  always_comb begin
    w_pick = '0;
    for (int k = NUM_SRC; k >= 1; k--)
      if (r_req[(int'(r_rr_last) + k) % NUM_SRC]) w_pick = NUM_SRC'(1) << ((int'(r_rr_last) + k) % NUM_SRC);
  end
  always_comb begin
    w_g    = '0;
    w_data = '0;
    for (int i = 0; i < NUM_SRC; i++)
      if (r_grant[i]) begin
        w_g    = IW'(i);
        w_data = s_axis_tdata[i*DW +: DW];
      end
  end
  // grant is only non-zero in XFER, so these muxes are naturally quiet elsewhere.
  assign m_axis_tdata  = w_data;
  assign m_axis_tvalid = |(r_grant & s_axis_tvalid);
  assign s_axis_tready = r_grant & {NUM_SRC{m_axis_tready}};
  assign w_hs          = m_axis_tvalid & m_axis_tready;
  assign w_end         = w_hs & (r_cnt == LAST_BEAT);
  assign m_axis_tlast  = (r_cnt == LAST_BEAT) & m_axis_tvalid;
  assign grant         = r_grant;
  assign busy          = r_busy;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    w_next = r_state == IDLE ? (|s_axis_tvalid ? ARB : IDLE) :
             r_state == ARB  ? (|r_req ? XFER : IDLE) :
             (w_end ? IDLE : XFER);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_req     <= '0;
      r_grant   <= '0;
      r_busy    <= 1'b0;
      r_cnt     <= '0;
      r_rr_last <= IW'(NUM_SRC - 1);
    end else begin
      if (r_state == IDLE) r_req <= s_axis_tvalid;
      if (r_state == ARB) begin
        r_grant <= w_pick;
        r_busy  <= |w_pick;
        r_cnt   <= '0;
      end else if (w_end) begin
        r_grant   <= '0;
        r_busy    <= 1'b0;
        r_rr_last <= w_g;
      end else if (w_hs) r_cnt <= r_cnt + 1'b1;
    end
`ifdef PSYS_ARB_FRAME_CNT_EN
  logic [NUM_SRC*16-1:0] r_fcnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_fcnt <= '0;
    else
      for (int i = 0; i < NUM_SRC; i++)
        if (w_end & r_grant[i]) r_fcnt[i*16 +: 16] <= r_fcnt[i*16 +: 16] + 16'd1;
  assign frame_cnt = r_fcnt;
`endif
endmodule

// File: tb/tb_psys_in128_frame_arbiter.sv
// tb_psys_in128_frame_arbiter: scoreboard bench with a frame-level round-robin reference model.
module tb_psys_in128_frame_arbiter;
  localparam int N = 4, B = 12, DW = 128;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [N*DW-1:0] s_axis_tdata;
  logic [N-1:0]    s_axis_tvalid, s_axis_tready, grant;
  logic [DW-1:0]   m_axis_tdata;
  logic            m_axis_tvalid, m_axis_tready, m_axis_tlast, busy;
`ifdef PSYS_ARB_FRAME_CNT_EN
  logic [N*16-1:0] frame_cnt;
`endif
  psys_in128_frame_arbiter #(.NUM_SRC(N), .BEATS_PER_FRAME(B), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .grant(grant), .busy(busy)
`ifdef PSYS_ARB_FRAME_CNT_EN
    , .frame_cnt(frame_cnt)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {logic [DW-1:0] d; int src; bit last; bit first;} beat_t;
  beat_t exp_q[$];
  logic [DW-1:0] dat [N][48];
  int total[N], ptr[N];
  bit rdy_rand, drop_en, gap_exact;
  int n_chk = 0, n_pass = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask
  // Sources: continuously valid at frame boundaries, may drop valid only mid-frame.
  initial begin
    logic [N-1:0] hs;
    bit v;
    s_axis_tvalid = '0;
    s_axis_tdata  = '0;
    m_axis_tready = 1'b0;
    for (int s = 0; s < N; s++) begin total[s] = 0; ptr[s] = 0; end
    forever begin
      @(negedge clk);
      hs = s_axis_tvalid & s_axis_tready;
      @(posedge clk);
      #1;
      for (int s = 0; s < N; s++) begin
        if (hs[s]) ptr[s]++;
        v = ptr[s] < total[s] ? ((ptr[s] % B == 0 || !drop_en) ? 1'b1 : ($urandom_range(9) > 2)) : 1'b0;
        s_axis_tvalid[s] = v;
        s_axis_tdata[s*DW +: DW] = ptr[s] < total[s] ? dat[s][ptr[s]] : {$urandom, $urandom, $urandom, $urandom};
      end
      m_axis_tready = rdy_rand ? ($urandom_range(3) != 0) : 1'b1;
    end
  end
  // Monitor: the presented beat must always be the scoreboard head; pop on handshake.
  initial begin
    beat_t h;
    int last_tl, gap;
    last_tl = -100;
    forever begin
      @(negedge clk);
      if (!rst_n) last_tl = -100;
      else if (m_axis_tvalid) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_beat: got %h expected no beat", m_axis_tdata);
        end else begin
          h = exp_q[0];
          chk("tdata", m_axis_tdata, h.d);
          chk("tlast", m_axis_tlast, h.last);
          if (m_axis_tready) begin
            chk("grant", grant, 1 << h.src);
            chk("s_tready", s_axis_tready, 1 << h.src);
            chk("busy", busy, 1);
            if (h.first && last_tl >= 0) begin
              gap = cyc - last_tl;
              if (gap_exact) chk("gap", gap, 3);
              else chk("gap_min3", gap >= 3, 1);
            end
            if (h.last) last_tl = cyc;
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_s_tready", s_axis_tready, 0);
    @(negedge clk);
    for (int s = 0; s < N; s++) begin total[s] = 0; ptr[s] = 0; end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  // Reference: serve pending frames round-robin starting after source N-1.
  task automatic start(input int f0, input int f1, input int f2, input int f3);
    int f[N], left[N];
    int last, pick, s;
    beat_t e;
    f[0] = f0; f[1] = f1; f[2] = f2; f[3] = f3;
    last = N - 1;
    for (int i = 0; i < N; i++) begin
      left[i] = f[i];
      for (int j = 0; j < f[i] * B; j++) dat[i][j] = {$urandom, $urandom, $urandom, $urandom};
    end
    forever begin
      pick = -1;
      for (int k = 1; k <= N; k++) begin
        s = (last + k) % N;
        if (pick < 0 && left[s] > 0) pick = s;
      end
      if (pick < 0) break;
      for (int b = 0; b < B; b++) begin
        e.d = dat[pick][(f[pick] - left[pick]) * B + b];
        e.src = pick;
        e.last = (b == B - 1);
        e.first = (b == 0);
        exp_q.push_back(e);
      end
      left[pick]--;
      last = pick;
    end
    for (int i = 0; i < N; i++) total[i] = f[i] * B;
  endtask
  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 4000) begin @(negedge clk); t++; end
    n_chk++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d beats outstanding, required 0", exp_q.size());
    repeat (4) @(negedge clk);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
  initial begin
    int t;
    rdy_rand = 0; drop_en = 0; gap_exact = 1;
    repeat (3) @(negedge clk);
    // single source: grant two cycles after valid, tlast on beat 12, grant drops after
    do_reset();
    @(negedge clk);
    start(1, 0, 0, 0);
    @(negedge clk); chk("t1_grant_c0", grant, 0);
    @(negedge clk); chk("t1_grant_c1", grant, 0);
    @(negedge clk); chk("t1_grant_c2", grant, 1);
    repeat (11) @(negedge clk);
    chk("t1_tlast_b12", m_axis_tlast, 1);
    @(negedge clk);
    chk("t1_grant_end", grant, 0);
    chk("t1_busy_end", busy, 0);
    drain();
    // all sources, continuous: strict rotation with exact 2-cycle bubbles
    do_reset();
    @(negedge clk);
    start(2, 2, 2, 2);
    drain();
    // random frames, random source stalls mid-frame and random downstream stalls
    rdy_rand = 1; drop_en = 1; gap_exact = 0;
    repeat (4) begin
      do_reset();
      @(negedge clk);
      start($urandom_range(3), $urandom_range(3), $urandom_range(3), $urandom_range(3));
      drain();
    end
    // reset mid-frame, then pointer restarts at source 0
    rdy_rand = 0; drop_en = 0; gap_exact = 1;
    do_reset();
    @(negedge clk);
    start(0, 1, 0, 0);
    t = 0;
    while (ptr[1] < 5 && t < 200) begin @(negedge clk); t++; end
    chk("t4_reached_beat5", ptr[1] >= 5, 1);
    do_reset();
    @(negedge clk);
    start(0, 1, 0, 1);
    drain();
    // three frames from source 0 and one from source 3
    do_reset();
    @(negedge clk);
    start(3, 0, 0, 1);
    drain();
`ifdef PSYS_ARB_FRAME_CNT_EN
    chk("frame_cnt", frame_cnt, 64'h0001_0000_0000_0003);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
